// File: rtl/shift_add_mac.sv
// rtl/shift_add_mac.sv - sequential shift-add multiply-accumulate, one multiplier bit per cycle
module shift_add_mac #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc_next;

    // Partial sum after this cycle's conditional add; the final step's add must reach product.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Control and datapath: accept in IDLE/DONE, shift-add in RUN, publish on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc    <= {{WIDTH{1'b0}}, addend};
                        mcand  <= {{WIDTH{1'b0}}, multiplicand};
                        mplier <= multiplier;
                        count  <= '0;
                        valid  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        product <= acc_next;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mac.sv
// tb/tb_shift_add_mac.sv - self-checking bench for shift_add_mac
module tb_shift_add_mac;

    localparam int W = 16;

    logic            clk;
    logic            rst;
    logic            start;
    logic [W-1:0]    multiplicand;
    logic [W-1:0]    multiplier;
    logic [W-1:0]    addend;
    logic [2*W-1:0]  product;
    logic            busy;
    logic            valid;

    int tests;
    int fails;

    logic [2*W-1:0] sb[$];

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   c;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    shift_add_mac #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .product      (product),
        .busy         (busy),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        logic [2*W-1:0] e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: result with empty scoreboard got %0h expected none", name, product);
        end else begin
            e = sb.pop_front();
            check(name, product, e);
        end
    endtask

    // Restoring division, used to build (quotient, divisor, remainder) triples.
    task automatic rdiv(input logic [W-1:0] d, input logic [W-1:0] m,
                        output logic [W-1:0] q, output logic [W-1:0] r);
        logic [W:0] rem;
        rem = '0;
        q   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            rem = {rem[W-1:0], d[i]};
            if (rem >= {1'b0, m}) begin
                rem  = rem - {1'b0, m};
                q[i] = 1'b1;
            end
        end
        r = rem[W-1:0];
    endtask

    // One operation; glitch>0 pulses start with other operands at that RUN cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [2*W-1:0] exp, input int glitch, input bit timing);
        int busy_cycles;
        int lat;
        bit seen;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        start        = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        busy_cycles = 0;
        lat = -1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (valid) begin
                seen = 1'b1;
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
            start = (glitch != 0 && k == glitch);
            if (start) begin
                multiplicand = 16'd9;
                multiplier   = 16'd9;
                addend       = 16'd0;
            end else begin
                multiplicand = W'($urandom);
                multiplier   = W'($urandom);
                addend       = W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL timeout: valid never rose for %0h*%0h+%0h", a, b, c);
            void'(sb.pop_front());
        end else begin
            pop_check("product");
            if (timing) begin
                check("latency", lat, 16);
                check("busy_cycles", busy_cycles, 16);
                @(negedge clk);
                @(negedge clk);
                check("valid_level", valid, 1'b1);
                check("product_hold", product, exp);
            end
        end
    endtask

    initial begin
        logic [W-1:0] d, m, q, r;
        int vcount;
        int gap;
        bit got1;

        tests = 0;
        fails = 0;

        vecs[0] = '{16'd10,    16'd100,   16'd0,     32'd1000};
        vecs[1] = '{16'd17,    16'd726,   16'd3,     32'd12345};
        vecs[2] = '{16'd255,   16'd257,   16'd0,     32'd65535};
        vecs[3] = '{16'hFFFF,  16'hFFFF,  16'hFFFF,  32'hFFFF_0000};
        vecs[4] = '{16'd15,    16'd0,     16'd0,     32'd0};
        vecs[5] = '{16'd0,     16'd9,     16'd7,     32'd7};
        vecs[6] = '{16'hFFFF,  16'd1,     16'd0,     32'h0000_FFFF};
        vecs[7] = '{16'h8000,  16'h8000,  16'h1234,  32'h4000_1234};

        // Reset state, start ignored while in reset
        rst = 1'b1;
        start = 1'b1;
        multiplicand = 16'd3;
        multiplier = 16'd3;
        addend = 16'd3;
        repeat (3) @(negedge clk);
        check("reset_product", product, 32'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_valid", valid, 1'b0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, 0, 1'b1);
        end

        // Back-to-back with start held high
        @(negedge clk);
        multiplicand = 16'd17;
        multiplier = 16'd726;
        addend = 16'd3;
        start = 1'b1;
        sb.push_back(32'd12345);
        sb.push_back(32'd65535);
        @(negedge clk);
        multiplicand = 16'd255;
        multiplier = 16'd257;
        addend = 16'd0;
        vcount = 0;
        gap = 0;
        got1 = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (got1) gap++;
            if (valid) begin
                if (!got1) begin
                    got1 = 1'b1;
                    gap = 0;
                    vcount = 1;
                    pop_check("b2b_first");
                end else if (gap == 1) begin
                    vcount++;
                end else begin
                    start = 1'b0;
                    pop_check("b2b_second");
                    break;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_valid_one_cycle", vcount, 1);
        check("b2b_spacing", gap, 17);
        check("b2b_drained", sb.size(), 0);
        sb.delete();

        // start during RUN is ignored
        run_op(16'd3, 16'd5, 16'd0, 32'd15, 5, 1'b1);

        // Reset mid-RUN aborts with no clock edge
        @(negedge clk);
        multiplicand = 16'd100;
        multiplier = 16'd200;
        addend = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", valid, 1'b0);
        check("abort_product", product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'd100, 16'd200, 16'd1, 32'd20001, 0, 1'b1);

        // Divider round trip
        for (int n = 0; n < 1000; n++) begin
            d = W'($urandom);
            m = W'($urandom);
            if (n % 4 == 0) m = W'($urandom_range(1, 20));
            if (m == 0) m = 16'd1;
            rdiv(d, m, q, r);
            run_op(m, q, r, {16'd0, d}, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
